sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller command port between three requesters inside gsoc: video scanout (port 0), CPU (port 1) and graphics/blitter (port 2).
- Video has fixed priority with a starvation guard. CPU and graphics alternate round-robin.
- One transaction is outstanding at a time. Read data and write acknowledges are routed back to the requester that owned the grant.
- Sits between the requester buses and the SDRAM controller, in the clk_sdram domain.

---
 rtl/sdram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-port arbiter in front of the SDRAM controller command port.
// Optional SDRAM_ARB_STATS_EN adds grant/stall counters and a stats clear input.
module sdram_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int MAX_VID_RUN = 4
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [2:0]              req_i,
    input  logic [2:0]              we_i,
    input  logic [3*ADDR_W-1:0]     addr_i,
    input  logic [3*DATA_W-1:0]     wdata_i,
    input  logic [3*DATA_W/8-1:0]   wmask_i,
    output logic [2:0]              ack_o,
    output logic [2:0]              rvalid_o,
    output logic [DATA_W-1:0]       rdata_o,
`ifdef SDRAM_ARB_STATS_EN
    input  logic                    stats_clr_i,
    output logic [47:0]             grant_cnt_o,
    output logic [15:0]             stall_cnt_o,
`endif
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    output logic [DATA_W/8-1:0]     mem_wmask_o,
    input  logic                    mem_ack_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_W-1:0]       mem_rdata_i
);

    localparam int MW = DATA_W / 8;
    localparam int RW = $clog2(MAX_VID_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_VID_RUN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [RW-1:0]     vid_run_q, vid_run_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;

    logic [ADDR_W-1:0] addr_a  [3];
    logic [DATA_W-1:0] wdata_a [3];
    logic [MW-1:0]     wmask_a [3];

    logic       other;
    logic       vid_ok;
    logic [2:0] gnt;
    logic [1:0] gnt_idx;
    logic [2:0] own_oh;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            addr_a[p]  = addr_i[p*ADDR_W +: ADDR_W];
            wdata_a[p] = wdata_i[p*DATA_W +: DATA_W];
            wmask_a[p] = wmask_i[p*MW +: MW];
        end
    end

    // Video loses only when its run is exhausted and someone else waits.
    always_comb begin
        other  = req_i[1] | req_i[2];
        vid_ok = req_i[0] && !(vid_run_q == RUN_MAX && other);
        gnt    = 3'b000;
        if (state_q == S_IDLE) begin
            if (vid_ok)
                gnt = 3'b001;
            else if (req_i[1] && req_i[2])
                gnt = rr_q ? 3'b100 : 3'b010;
            else if (req_i[1])
                gnt = 3'b010;
            else if (req_i[2])
                gnt = 3'b100;
        end
    end

    always_comb begin
        gnt_idx = 2'd0;
        unique case (1'b1)
            gnt[1]:  gnt_idx = 2'd1;
            gnt[2]:  gnt_idx = 2'd2;
            default: gnt_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        vid_run_d = vid_run_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    state_d = S_ISSUE;
                    owner_d = gnt_idx;
                    we_d    = we_i[gnt_idx];
                    addr_d  = addr_a[gnt_idx];
                    wdata_d = wdata_a[gnt_idx];
                    wmask_d = wmask_a[gnt_idx];
                    if (gnt[0]) begin
                        if (!other)
                            vid_run_d = '0;
                        else if (vid_run_q != RUN_MAX)
                            vid_run_d = vid_run_q + RW'(1);
                    end else begin
                        vid_run_d = '0;
                        rr_d      = gnt[1];
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ack_i)
                    state_d = we_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 2'd0;
            rr_q      <= 1'b0;
            vid_run_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            vid_run_q <= vid_run_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

    assign own_oh      = 3'b001 << owner_q;
    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;
    assign ack_o       = (state_q == S_ISSUE && mem_ack_i) ? own_oh : 3'b000;
    assign rvalid_o    = (state_q == S_WAIT && mem_rvalid_i) ? own_oh : 3'b000;
    assign rdata_o     = (state_q == S_WAIT && mem_rvalid_i) ? mem_rdata_i : '0;

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] gcnt_q [3];
    logic [15:0] stall_q;
    logic        stall;

    assign stall = |(req_i & ~gnt);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int p = 0; p < 3; p++) gcnt_q[p] <= 16'd0;
            stall_q <= 16'd0;
        end else if (stats_clr_i) begin
            for (int p = 0; p < 3; p++) gcnt_q[p] <= 16'd0;
            stall_q <= 16'd0;
        end else begin
            for (int p = 0; p < 3; p++)
                if (gnt[p] && gcnt_q[p] != 16'hFFFF)
                    gcnt_q[p] <= gcnt_q[p] + 16'd1;
            if (stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign grant_cnt_o = {gcnt_q[2], gcnt_q[1], gcnt_q[0]};
    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter.
// Inputs change on the falling edge; outputs are checked there or 1 time unit later.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [2:0]  req_i, we_i;
    logic [71:0] addr_i;
    logic [95:0] wdata_i;
    logic [11:0] wmask_i;
    logic [2:0]  ack_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [23:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_ack_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef SDRAM_ARB_STATS_EN
    logic        stats_clr_i;
    logic [47:0] grant_cnt_o;
    logic [15:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    int waited;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wmask_i      (wmask_i),
        .ack_o        (ack_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
`ifdef SDRAM_ARB_STATS_EN
        .stats_clr_i  (stats_clr_i),
        .grant_cnt_o  (grant_cnt_o),
        .stall_cnt_o  (stall_cnt_o),
`endif
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic we, input logic [23:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        we_i[p]          = we;
        addr_i[p*24+:24] = a;
        wdata_i[p*32+:32] = d;
        wmask_i[p*4+:4]  = m;
    endtask

    // Serve one transaction as a zero/low-latency controller.
    task automatic txn(input string tag, input logic [2:0] exp_oh,
                       input logic wr, input logic [23:0] exp_addr,
                       input int ack_dly, input logic [31:0] rd);
        int w;
        w = 0;
        while (!mem_req_o && w < 8) begin
            @(negedge clk);
            w++;
        end
        waited = w;
        chk({tag, "_req"}, {95'd0, mem_req_o}, 96'd1);
        if (!mem_req_o) return;
        chk({tag, "_addr"}, {72'd0, mem_addr_o}, {72'd0, exp_addr});
        chk({tag, "_we"}, {95'd0, mem_we_o}, {95'd0, wr});
        repeat (ack_dly) @(negedge clk);
        chk({tag, "_noack"}, {93'd0, ack_o}, 96'd0);
        mem_ack_i = 1'b1;
        #1;
        chk({tag, "_ack"}, {93'd0, ack_o}, {93'd0, exp_oh});
        @(negedge clk);
        mem_ack_i = 1'b0;
        if (!wr) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rd;
            #1;
            chk({tag, "_rvalid"}, {93'd0, rvalid_o}, {93'd0, exp_oh});
            chk({tag, "_rdata"}, {64'd0, rdata_o}, {64'd0, rd});
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'd0;
        end else begin
            #1;
            chk({tag, "_wr_norv"}, {93'd0, rvalid_o}, 96'd0);
            chk({tag, "_wr_idle"}, {95'd0, mem_req_o}, 96'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i    = 1'b0;
        req_i        = 3'b000;
        we_i         = 3'b000;
        addr_i       = '0;
        wdata_i      = '0;
        wmask_i      = '0;
        mem_ack_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
`ifdef SDRAM_ARB_STATS_EN
        stats_clr_i  = 1'b0;
`endif
        #1;
        chk("rst_req", {95'd0, mem_req_o}, 96'd0);
        chk("rst_ack", {93'd0, ack_o}, 96'd0);
        chk("rst_rv", {93'd0, rvalid_o}, 96'd0);
        chk("rst_addr", {72'd0, mem_addr_o}, 96'd0);
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);

        // CPU read, explicit latencies.
        set_port(1, 1'b0, 24'h000123, 32'h0, 4'h0);
        req_i = 3'b010;
        #1;
        chk("t1_req_lat0", {95'd0, mem_req_o}, 96'd0);
        txn("t1", 3'b010, 1'b0, 24'h000123, 1, 32'hDEADBEEF);
        chk("t1_latency", 96'(waited), 96'd1);
        req_i = 3'b000;

        // Graphics write; fields must pass unchanged.
        set_port(2, 1'b1, 24'h00FF00, 32'hA5A5A5A5, 4'b0011);
        req_i = 3'b100;
        @(negedge clk);
        chk("t2_wdata", {64'd0, mem_wdata_o}, {64'd0, 32'hA5A5A5A5});
        chk("t2_wmask", {92'd0, mem_wmask_o}, {92'd0, 4'b0011});
        txn("t2", 3'b100, 1'b1, 24'h00FF00, 0, 32'h0);
        req_i = 3'b000;

        // Late ack / rvalid while idle must not pulse anything.
        mem_ack_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        #1;
        chk("idle_ack", {93'd0, ack_o}, 96'd0);
        chk("idle_rv", {93'd0, rvalid_o}, 96'd0);
        @(negedge clk);
        mem_ack_i    = 1'b0;
        mem_rvalid_i = 1'b0;

        // CPU vs graphics round-robin.
        set_port(1, 1'b0, 24'h000100, 32'h0, 4'h0);
        set_port(2, 1'b0, 24'h000200, 32'h0, 4'h0);
        req_i = 3'b110;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                txn("rr_c", 3'b010, 1'b0, 24'h000100, 0, 32'h1000 + i);
            else
                txn("rr_g", 3'b100, 1'b0, 24'h000200, 0, 32'h2000 + i);
        end
        req_i = 3'b000;

        // Video starvation guard with CPU held.
        set_port(0, 1'b0, 24'h000010, 32'h0, 4'h0);
        set_port(1, 1'b0, 24'h000020, 32'h0, 4'h0);
        req_i = 3'b011;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                txn("vid_c", 3'b010, 1'b0, 24'h000020, 0, 32'h3000 + i);
            else
                txn("vid_v", 3'b001, 1'b0, 24'h000010, 0, 32'h4000 + i);
        end
        req_i = 3'b000;

        // Reset while waiting for read data.
        set_port(1, 1'b0, 24'h000456, 32'h0, 4'h0);
        req_i = 3'b010;
        @(negedge clk);
        mem_ack_i = 1'b1;
        #1;
        chk("rst_mid_ack", {93'd0, ack_o}, 96'b010);
        @(negedge clk);
        mem_ack_i = 1'b0;
        req_i     = 3'b000;
        reset_n_i = 1'b0;
        #1;
        chk("rst_mid_addr", {72'd0, mem_addr_o}, 96'd0);
        chk("rst_mid_req", {95'd0, mem_req_o}, 96'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        #1;
        chk("rst_mid_rv", {93'd0, rvalid_o}, 96'd0);
        chk("rst_mid_rd", {64'd0, rdata_o}, 96'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        chk("rst_post_rv", {93'd0, rvalid_o}, 96'd0);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        set_port(1, 1'b0, 24'h000789, 32'h0, 4'h0);
        req_i = 3'b010;
        txn("rst_next", 3'b010, 1'b0, 24'h000789, 0, 32'hCAFEF00D);
        req_i = 3'b000;

`ifdef SDRAM_ARB_STATS_EN
        stats_clr_i = 1'b1;
        @(negedge clk);
        stats_clr_i = 1'b0;
        set_port(0, 1'b0, 24'h000011, 32'h0, 4'h0);
        req_i = 3'b001;
        for (int i = 0; i < 3; i++)
            txn("st_v", 3'b001, 1'b0, 24'h000011, 0, 32'h5);
        set_port(1, 1'b0, 24'h000022, 32'h0, 4'h0);
        req_i = 3'b010;
        for (int i = 0; i < 2; i++)
            txn("st_c", 3'b010, 1'b0, 24'h000022, 0, 32'h6);
        req_i = 3'b000;
        @(negedge clk);
        chk("st_gcnt", {48'd0, grant_cnt_o}, {48'd0, 16'd0, 16'd2, 16'd3});
        stats_clr_i = 1'b1;
        @(negedge clk);
        stats_clr_i = 1'b0;
        chk("st_clr_g", {48'd0, grant_cnt_o}, 96'd0);
        chk("st_clr_s", {80'd0, stall_cnt_o}, 96'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
